// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time from execute, drives a
// single-outstanding bus transaction and returns an extended load result.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        Mem_Valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  Err,
    output logic [31:0] ReadData,
    output logic        Bus_Req,
    output logic        Bus_WE,
    output logic [31:0] Bus_Addr,
    output logic [3:0]  Bus_ByteEn,
    output logic [31:0] Bus_WData,
    input  logic [31:0] Bus_RData,
    input  logic        Bus_Ack
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        accept_s;

    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (lo[0] == 1'b0);
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en_of(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{wd[7:0]}};
            2'b01:   w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    // Select the addressed lane of the bus word, then sign- or zero-extend.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign accept_s = Mem_Valid && (MemRead ^ MemWrite);

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = ERR_OK;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (funct3_legal(Funct3, MemWrite) && is_aligned(Funct3, ALUResult[1:0])) begin
                        state_d  = REQ;
                        cnt_d    = 8'd0;
                        store_d  = MemWrite;
                        funct3_d = Funct3;
                        lane_d   = ALUResult[1:0];
                        addr_d   = {ALUResult[31:2], 2'b00};
                        be_d     = byte_en_of(Funct3, ALUResult[1:0]);
                        wdata_d  = wdata_of(Funct3, WriteData);
                    end else begin
                        state_d = DONE;
                        err_d   = ERR_ALIGN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (Bus_Ack) begin
                    state_d = DONE;
                    err_d   = ERR_OK;
                    if (!store_q) begin
                        rdata_d = load_extract(funct3_q, lane_q, Bus_RData);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                    state_d = DONE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        req_d  = (state_d == REQ);
        we_d   = (state_d == REQ) && store_d;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            lane_q   <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 2'b00;
            rdata_q  <= 32'h0000_0000;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            be_q     <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            req_q    <= req_d;
            we_q     <= we_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Err        = err_q;
    assign ReadData   = rdata_q;
    assign Bus_Req    = req_q;
    assign Bus_WE     = we_q;
    assign Bus_Addr   = addr_q;
    assign Bus_ByteEn = be_q;
    assign Bus_WData  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// corner sequences, then random transactions against an arithmetic model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        Mem_Valid = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        Busy, Done, Bus_Req, Bus_WE;
    logic [1:0]  Err;
    logic [31:0] ReadData, Bus_Addr, Bus_WData;
    logic [3:0]  Bus_ByteEn;
    logic [31:0] Bus_RData = 32'h0;
    logic        Bus_Ack = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd = 32'h0;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          ack;
        logic [1:0]  err;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[15];

    load_store_unit #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .Mem_Valid(Mem_Valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .Err(Err), .ReadData(ReadData), .Bus_Req(Bus_Req),
        .Bus_WE(Bus_WE), .Bus_Addr(Bus_Addr), .Bus_ByteEn(Bus_ByteEn), .Bus_WData(Bus_WData),
        .Bus_RData(Bus_RData), .Bus_Ack(Bus_Ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_junk();
        Mem_Valid = 1'($urandom);
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        Funct3    = 3'($urandom);
        ALUResult = $urandom;
        WriteData = $urandom;
    endtask

    // Reference model: expectations derived from access size and byte offset.
    function automatic vec_t mk(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata, input int ack,
                                input logic [31:0] prev);
        vec_t        v;
        int          lane, size;
        bit          legal, aligned;
        logic [31:0] sh, val;
        v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata; v.ack = ack;
        v.rd = prev; v.be = 4'h0; v.wdata = 32'h0; v.err = 2'b00;
        lane    = int'(addr % 32'd4);
        size    = 1 << f3[1:0];
        legal   = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        aligned = (lane % size) == 0;
        if (!legal || !aligned) begin
            v.err = 2'b01;
        end else begin
            v.be = 4'(((1 << size) - 1) << lane);
            if (size == 1)      v.wdata = wd[7:0] * 32'h01010101;
            else if (size == 2) v.wdata = wd[15:0] * 32'h00010001;
            else                v.wdata = wd;
            if (ack >= 1 && ack <= TO) begin
                v.err = 2'b00;
                if (!st) begin
                    sh = rdata >> (8 * lane);
                    if (size == 1) begin
                        val = sh & 32'hFF;
                        if (!f3[2] && val >= 32'h80) val = val + 32'hFFFFFF00;
                    end else if (size == 2) begin
                        val = sh & 32'hFFFF;
                        if (!f3[2] && val >= 32'h8000) val = val + 32'hFFFF0000;
                    end else begin
                        val = rdata;
                    end
                    v.rd = val;
                end
            end else begin
                v.err = 2'b10;
            end
        end
        return v;
    endfunction

    // Issue one request and check every cycle until the unit is idle again.
    task automatic run_txn(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr  = {v.addr[31:2], 2'b00};
        Mem_Valid = 1'b1;
        MemRead   = !v.st;
        MemWrite  = v.st;
        Funct3    = v.f3;
        ALUResult = v.addr;
        WriteData = v.wd;
        Bus_Ack   = 1'b0;
        @(posedge CLK); #1;
        if (v.err != 2'b01) begin
            for (int c = 1; c <= TO; c++) begin
                drive_junk();
                Bus_Ack   = (c == v.ack);
                Bus_RData = (c == v.ack) ? v.rdata : $urandom;
                chk("req_busy", 32'(Busy), 32'h1);
                chk("req_bus_req", 32'(Bus_Req), 32'h1);
                chk("req_done", 32'(Done), 32'h0);
                chk("req_we", 32'(Bus_WE), 32'(v.st));
                chk("req_addr", Bus_Addr, exp_addr);
                chk("req_byteen", 32'(Bus_ByteEn), 32'(v.be));
                if (v.st) chk("req_wdata", Bus_WData, v.wdata);
                @(posedge CLK); #1;
                if (c == v.ack) break;
            end
        end
        drive_junk();
        Bus_Ack = 1'($urandom);
        chk("done_pulse", 32'(Done), 32'h1);
        chk("done_err", 32'(Err), 32'(v.err));
        chk("done_busy", 32'(Busy), 32'h1);
        chk("done_bus_req", 32'(Bus_Req), 32'h0);
        chk("done_we", 32'(Bus_WE), 32'h0);
        chk("done_rdata", ReadData, v.rd);
        @(posedge CLK); #1;
        Mem_Valid = 1'b0;
        Bus_Ack   = 1'b0;
        chk("idle_done", 32'(Done), 32'h0);
        chk("idle_busy", 32'(Busy), 32'h0);
        chk("idle_rdata", ReadData, v.rd);
        model_rd = v.rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1,  2'b00, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1,  2'b00, 4'h8, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1,  2'b00, 4'h8, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        2,  2'b00, 4'hC, 32'hABCDABCD, 32'h00000080};
        tbl[4]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1,  2'b01, 4'h0, 32'h0,        32'h00000080};
        tbl[5]  = '{1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0,        0,  2'b10, 4'hF, 32'h11223344, 32'h00000080};
        tbl[6]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 1,  2'b00, 4'hC, 32'h0,        32'hFFFF8001};
        tbl[7]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 4,  2'b00, 4'hC, 32'h0,        32'h00008001};
        tbl[8]  = '{1'b0, 3'b101, 32'h000, 32'h0,        32'h1234FEDC, 1,  2'b00, 4'h3, 32'h0,        32'h0000FEDC};
        tbl[9]  = '{1'b1, 3'b000, 32'h001, 32'h000000AB, 32'h0,        3,  2'b00, 4'h2, 32'hABABABAB, 32'h0000FEDC};
        tbl[10] = '{1'b1, 3'b100, 32'h000, 32'h00000055, 32'h0,        1,  2'b01, 4'h0, 32'h0,        32'h0000FEDC};
        tbl[11] = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        1,  2'b01, 4'h0, 32'h0,        32'h0000FEDC};
        tbl[12] = '{1'b0, 3'b010, 32'h004, 32'h0,        32'hCAFEF00D, 16, 2'b00, 4'hF, 32'h0,        32'hCAFEF00D};
        tbl[13] = '{1'b0, 3'b011, 32'h008, 32'h0,        32'h0,        1,  2'b01, 4'h0, 32'h0,        32'hCAFEF00D};
        tbl[14] = '{1'b0, 3'b000, 32'h000, 32'h0,        32'h0000007F, 2,  2'b00, 4'h1, 32'h0,        32'h0000007F};

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_err", 32'(Err), 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_bus_req", 32'(Bus_Req), 32'h0);
        chk("rst_we", 32'(Bus_WE), 32'h0);
        chk("rst_addr", Bus_Addr, 32'h0);
        chk("rst_byteen", 32'(Bus_ByteEn), 32'h0);
        chk("rst_wdata", Bus_WData, 32'h0);

        // Release reset and request immediately: acceptance on the next edge.
        @(negedge CLK);
        RESET_N = 1'b1;
        foreach (tbl[i]) run_txn(tbl[i]);

        // Ignored request combinations.
        Mem_Valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0;
        @(posedge CLK); #1;
        chk("both_dir_busy", 32'(Busy), 32'h0);
        chk("both_dir_req", 32'(Bus_Req), 32'h0);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge CLK); #1;
        chk("no_dir_busy", 32'(Busy), 32'h0);
        chk("no_dir_done", 32'(Done), 32'h0);
        Mem_Valid = 1'b0; Bus_Ack = 1'b1;
        @(posedge CLK); #1;
        chk("idle_ack_done", 32'(Done), 32'h0);
        chk("idle_ack_rdata", ReadData, model_rd);
        Bus_Ack = 1'b0;

        // Reset asserted in the third REQ cycle.
        Mem_Valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h40;
        @(posedge CLK); #1;
        Mem_Valid = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        chk("pre_rst_req", 32'(Bus_Req), 32'h1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_req", 32'(Bus_Req), 32'h0);
        chk("mid_rst_busy", 32'(Busy), 32'h0);
        chk("mid_rst_done", 32'(Done), 32'h0);
        chk("mid_rst_rdata", ReadData, 32'h0);
        chk("mid_rst_addr", Bus_Addr, 32'h0);
        model_rd = 32'h0;
        @(posedge CLK); #1;
        chk("rst_hold_done", 32'(Done), 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        run_txn(mk(1'b0, 3'b010, 32'h1C, 32'h0, 32'h13579BDF, 1, model_rd));

        // Random traffic against the model, with occasional idle cycles.
        for (int i = 0; i < 150; i++) begin
            run_txn(mk(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 18)), model_rd));
            if ($urandom_range(0, 3) == 0) begin
                Bus_Ack = 1'($urandom);
                @(posedge CLK); #1;
                Bus_Ack = 1'b0;
                chk("gap_busy", 32'(Busy), 32'h0);
                chk("gap_rdata", ReadData, model_rd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
